// File: rtl/unpadding_pkg.sv
// Shared image-toolkit definitions: default geometry, BRAM address widths and
// the run-control state encoding used by the padding/unpadding blocks.
package unpadding_pkg;

  localparam int IMG_N  = 16;
  localparam int IMG_P  = 2;
  localparam int IMG_W  = IMG_N + 2 * IMG_P;
  localparam int SRC_AW = 15;
  localparam int DST_AW = 14;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a 0..n-1 counter, never zero even for a 1-pixel image.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpadding_if.sv
// Source/destination BRAM port bundle between the cropper (master) and the
// two block memories (slave).
interface unpadding_if;
  import unpadding_pkg::*;

  logic              src_ena;
  logic [SRC_AW-1:0] src_addr;
  logic [PIX_W-1:0]  src_dout;
  logic              dst_ena;
  logic              dst_wea;
  logic [DST_AW-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_din;

  modport master (
    output src_ena, src_addr,
    input  src_dout,
    output dst_ena, dst_wea, dst_addr, dst_din
  );

  modport slave (
    input  src_ena, src_addr,
    output src_dout,
    input  dst_ena, dst_wea, dst_addr, dst_din
  );
endinterface

// File: rtl/unpad_addr_gen.sv
// Row/column walker for the cropped image: steps the padded read address and
// the linear write address one pixel at a time using adders only.
module unpad_addr_gen
  import unpadding_pkg::*;
#(
  parameter int N = IMG_N,
  parameter int P = IMG_P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [SRC_AW-1:0] src_addr,
  output logic [DST_AW-1:0] dst_addr,
  output logic              last
);
  localparam int W  = N + 2 * P;
  localparam int CW = cnt_w(N);
  localparam logic [SRC_AW-1:0] SRC_START = SRC_AW'(P * W + P);
  localparam logic [SRC_AW-1:0] ROW_SKIP  = SRC_AW'(2 * P + 1);
  localparam logic [CW-1:0]     LAST_IDX  = CW'(N - 1);

  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SRC_AW-1:0] src_q, src_d;
  logic [DST_AW-1:0] dst_q, dst_d;
  logic              end_of_row;

  assign end_of_row = (col_q == LAST_IDX);
  assign last       = end_of_row && (row_q == LAST_IDX);
  assign src_addr   = src_q;
  assign dst_addr   = dst_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    src_d = src_q;
    dst_d = dst_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      src_d = SRC_START;
      dst_d = '0;
    end else if (step) begin
      dst_d = dst_q + DST_AW'(1);
      // Leaving a row skips the right border of this row and the left border of the next.
      if (end_of_row) begin
        col_d = '0;
        row_d = row_q + CW'(1);
        src_d = src_q + ROW_SKIP;
      end else begin
        col_d = col_q + CW'(1);
        src_d = src_q + SRC_AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      src_q <= src_d;
      dst_q <= dst_d;
    end
  end

endmodule

// File: rtl/unpadding.sv
// Border stripper: reads an (N+2P)^2 padded image from the source BRAM and
// writes its central N^2 pixels, row-major, to the destination BRAM.
module unpadding
  import unpadding_pkg::*;
#(
  parameter int N = IMG_N,
  parameter int P = IMG_P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  output logic         busy,
  output logic         done,
  unpadding_if.master  bus
);
  localparam int W = N + 2 * P;
  localparam logic [DST_AW-1:0] LAST_DST = DST_AW'(N * N - 1);

  generate
    if (W * W > 32768 || N * N > 16384) begin : g_bad_params
      $error("unpadding: image geometry does not fit the BRAM address space");
    end
  endgenerate

  state_t            state_q, state_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_all_q, rd_all_d;
  logic              wr_vld_q, wr_vld_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic [DST_AW-1:0] rd_dst_q, rd_dst_d;
  logic [DST_AW-1:0] wr_dst_q, wr_dst_d;

  logic              gen_clr;
  logic              gen_step;
  logic              gen_last;
  logic [SRC_AW-1:0] gen_src;
  logic [DST_AW-1:0] gen_dst;

  unpad_addr_gen #(.N(N), .P(P)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gen_clr),
    .step     (gen_step),
    .src_addr (gen_src),
    .dst_addr (gen_dst),
    .last     (gen_last)
  );

  always_comb begin
    state_d    = state_q;
    rd_vld_d   = 1'b0;
    rd_all_d   = rd_all_q;
    wr_vld_d   = 1'b0;
    src_addr_d = src_addr_q;
    rd_dst_d   = rd_dst_q;
    wr_dst_d   = wr_dst_q;
    gen_clr    = 1'b0;
    gen_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_RUN;
          gen_clr  = 1'b1;
          rd_all_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!go) begin
          state_d = ST_IDLE;
        end else begin
          if (!rd_all_q) begin
            rd_vld_d   = 1'b1;
            src_addr_d = gen_src;
            rd_dst_d   = gen_dst;
            gen_step   = 1'b1;
            rd_all_d   = gen_last;
          end
          // Read stage -> write stage: the BRAM returns data one cycle after the address.
          wr_vld_d = rd_vld_q;
          wr_dst_d = rd_dst_q;
          if (wr_vld_q && (wr_dst_q == LAST_DST)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!go) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_vld_q   <= 1'b0;
      rd_all_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      src_addr_q <= '0;
      rd_dst_q   <= '0;
      wr_dst_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_vld_q   <= rd_vld_d;
      rd_all_q   <= rd_all_d;
      wr_vld_q   <= wr_vld_d;
      src_addr_q <= src_addr_d;
      rd_dst_q   <= rd_dst_d;
      wr_dst_q   <= wr_dst_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign bus.src_ena  = rd_vld_q;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_ena  = wr_vld_q;
  assign bus.dst_wea  = wr_vld_q;
  assign bus.dst_addr = wr_dst_q;
  assign bus.dst_din  = wr_vld_q ? bus.src_dout : '0;

endmodule

// File: tb/tb_unpadding.sv
// Bench for the border stripper: timing model from edge counts plus BRAM
// models, with directed image patterns and hand-computed anchor values.
module tb_unpadding;
  import unpadding_pkg::*;

  localparam int N  = IMG_N;
  localparam int P  = IMG_P;
  localparam int W  = IMG_W;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic busy, done;

  unpadding_if bus ();

  unpadding #(.N(N), .P(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] src_mem [0:W*W-1];
  logic [7:0] dst_mem [0:NN-1];
  logic [7:0] img     [0:NN-1];

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  bit ff_seen = 0;
  bit done_seen = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Padded-image address of cropped pixel k.
  function automatic int exp_src(input int k);
    return (k / N + P) * W + (k % N) + P;
  endfunction

  function automatic int count_bad_vs_src();
    int b = 0;
    for (int k = 0; k < NN; k++)
      if (dst_mem[k] !== src_mem[exp_src(k)]) b++;
    return b;
  endfunction

  // Source BRAM with one-cycle read latency; destination BRAM write port.
  always @(posedge clk) if (bus.src_ena) bus.src_dout <= src_mem[bus.src_addr];

  always @(posedge clk) begin
    if (rst_n && bus.dst_wea) begin
      dst_mem[bus.dst_addr[7:0]] <= bus.dst_din;
      wr_cnt++;
      if (bus.dst_din == 8'hFF) ff_seen = 1'b1;
    end
  end

  // Timing model: m_t counts edges since the edge that accepted go in idle.
  bit m_run = 0;
  bit m_done = 0;
  int m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_t <= 0;
    end else if (!go) begin
      m_run <= 1'b0; m_done <= 1'b0;
    end else if (m_run) begin
      if (m_t + 1 == NN + 2) begin
        m_run <= 1'b0; m_done <= 1'b1;
      end
      m_t <= m_t + 1;
    end else if (!m_done) begin
      m_run <= 1'b1; m_t <= 0;
    end
  end

  logic exp_rd, exp_wr;
  always @(negedge clk) begin
    if (chk_en) begin
      if (done) done_seen = 1'b1;
      if (!rst_n) begin
        check("rst_outputs", {busy, done, bus.src_ena, bus.dst_ena, bus.dst_wea}, 0);
      end else begin
        exp_rd = m_run && (m_t >= 1) && (m_t <= NN);
        exp_wr = m_run && (m_t >= 2) && (m_t <= NN + 1);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("src_ena", bus.src_ena, exp_rd);
        if (exp_rd) check("src_addr", bus.src_addr, exp_src(m_t - 1));
        check("dst_wea", bus.dst_wea, exp_wr);
        check("dst_ena", bus.dst_ena, exp_wr);
        if (exp_wr) begin
          check("dst_addr", bus.dst_addr, m_t - 2);
          check("dst_din", bus.dst_din, src_mem[exp_src(m_t - 2)]);
        end
      end
    end
  end

  // Call at posedge+1; raises go so the next edge is edge 0.
  task automatic run_to_done(output int edge_idx);
    edge_idx = -1;
    go = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin
        edge_idx = i;
        break;
      end
    end
  endtask

  task automatic stop_run();
    go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < W * W; i++) src_mem[i] = 8'(i);
  endtask

  task automatic fill_dst(input logic [7:0] v);
    for (int i = 0; i < NN; i++) dst_mem[i] = v;
  endtask

  int e;
  int bad;

  initial begin
    load_ramp();
    fill_dst(8'h00);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bus", {bus.src_ena, bus.src_addr, bus.dst_ena, bus.dst_wea, bus.dst_addr, bus.dst_din}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp image, go held
    wr_cnt = 0;
    run_to_done(e);
    check("ramp_done_edge", e, 258);
    check("ramp_writes", wr_cnt, 256);
    check("ramp_dst0", dst_mem[0], 8'd42);
    check("ramp_dst15", dst_mem[15], 8'd57);
    check("ramp_dst16", dst_mem[16], 8'd62);
    check("ramp_dst255", dst_mem[255], 8'd101);

    // go held in done
    wr_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("hold_writes", wr_cnt, 0);
    check("hold_done", done, 1);
    stop_run();
    check("done_clear", done, 0);

    // Border 0xFF, interior 0x00
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        src_mem[r * W + c] = (r < P || r >= P + N || c < P || c >= P + N) ? 8'hFF : 8'h00;
    fill_dst(8'h55);
    ff_seen = 1'b0;
    wr_cnt = 0;
    run_to_done(e);
    stop_run();
    bad = 0;
    for (int k = 0; k < NN; k++) if (dst_mem[k] !== 8'h00) bad++;
    check("border_no_ff", ff_seen, 0);
    check("border_all_zero", bad, 0);
    check("border_writes", wr_cnt, 256);

    // Abort after 100th write, then full rerun
    load_ramp();
    fill_dst(8'hAA);
    wr_cnt = 0;
    done_seen = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (wr_cnt == 100) break;
    end
    check("abort_reach_100", wr_cnt, 100);
    go = 1'b0;
    @(posedge clk); #1;
    check("abort_wea", bus.dst_wea, 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, 0);
    check("abort_busy", busy, 0);
    wr_cnt = 0;
    run_to_done(e);
    check("rerun_done_edge", e, 258);
    check("rerun_writes", wr_cnt, 256);
    check("rerun_image", count_bad_vs_src(), 0);
    stop_run();

    // Asynchronous reset at edge 50 of a run
    go = 1'b1;
    repeat (51) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_bus", {done, bus.src_ena, bus.src_addr, bus.dst_ena, bus.dst_wea, bus.dst_addr, bus.dst_din}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    check("midrst_hold", {busy, bus.dst_wea}, 0);
    fill_dst(8'h33);
    wr_cnt = 0;
    rst_n = 1'b1;
    run_to_done(e);
    check("postrst_done_edge", e, 258);
    check("postrst_writes", wr_cnt, 256);
    check("postrst_image", count_bad_vs_src(), 0);
    stop_run();

    // Random image padded with zeros, then cropped back
    for (int k = 0; k < NN; k++) img[k] = 8'($urandom_range(0, 255));
    for (int i = 0; i < W * W; i++) src_mem[i] = 8'h00;
    for (int k = 0; k < NN; k++) src_mem[(k / N + P) * W + (k % N) + P] = img[k];
    fill_dst(8'h00);
    wr_cnt = 0;
    run_to_done(e);
    stop_run();
    bad = 0;
    for (int k = 0; k < NN; k++) if (dst_mem[k] !== img[k]) bad++;
    check("roundtrip_image", bad, 0);
    check("roundtrip_writes", wr_cnt, 256);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
